softmax_window_ctrl: RTL
========================

Name: softmax_window_ctrl

Overview:
- Window sequencer for the lateral-inhibition rate softmax (6 pair channels, 8-bit Rel, 8-bit rates, 3-bit winner).
- Accepts one Rel vector per valid/ready handshake and holds it stable on the softmax inputs.
- Generates the flush and end-of-window cycle_start pulses, then captures rates and winner into a single-entry output buffer with a valid/ready handshake.
- Sits between the Rel/coincidence stage and the attention-weight consumer.

Parameters:
- REL_W, 8, width of each Rel/rate channel
- N_PAIR, 6, number of pair channels (ab, ac, ad, bc, bd, cd; packed ab in LSBs)
- DEF_WINDOW, 8'd64, window length used while cfg_window_len is 0 at reset-release bring-up (see Behaviour)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- abort  in  1  synchronous soft clear of the sequencer
- cfg_window_len  in  8  RUN length in clocks; 0 selects DEF_WINDOW
- in_valid  in  1  Rel vector valid
- in_ready  out  1  controller can accept a vector
- in_rel  in  48  packed Rel vector
- sm_cycle_start  out  1  to the softmax cycle_start
- sm_rel  out  48  held Rel vector to the softmax
- sm_rate  in  48  packed rates from the softmax
- sm_winner  in  3  winner from the softmax
- out_valid  out  1  result buffer valid
- out_ready  in  1  consumer accepts result
- out_rate  out  48  captured rates
- out_winner  out  3  captured winner
- win_count  out  16  completed windows, wraps at 2^16

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state = IDLE
  - sm_rel, out_rate, out_winner, win_count, run counter = 0
  - out_valid = 0, sm_cycle_start = 0
- FSM: IDLE, FLUSH, RUN, END, CAPTURE.
- Output decode from registered state:
  - in_ready = (state==IDLE).
  - sm_cycle_start = (state==FLUSH || state==END).
- IDLE:
  - On in_valid&&in_ready, load sm_rel<=in_rel.
  - Latch len = (cfg_window_len==0 ? DEF_WINDOW : cfg_window_len).
  - Go to FLUSH.
- FLUSH (1 clk):
  - Pulse clears stale softmax accumulators/counters; the rates the softmax latches here are discarded.
  - Next state RUN; run counter = 0.
- RUN:
  - Exactly len clocks; the counter increments each clock.
  - Leave to END when counter==len-1.
- END (1 clk):
  - Pulse makes the softmax latch rate = spikes counted during RUN and winner from the held sm_rel. sm_rel must be unchanged here.
  - Next state CAPTURE.
- CAPTURE:
  - sm_rate and sm_winner are valid and stay stable, since no further pulse occurs.
  - If !out_valid || out_ready: out_rate<=sm_rate, out_winner<=sm_winner, out_valid<=1, win_count++ (wraps), go IDLE.
  - Otherwise stall in CAPTURE.
- out_valid:
  - Cleared by out_ready when no new load occurs in the same clock.
  - A simultaneous load and out_ready in CAPTURE keeps out_valid=1 with the new data.
  - out_rate and out_winner are stable while out_valid && !out_ready.
- Latency: accept at edge t → sm_cycle_start high cycles t+1 and t+len+2 → out_valid high from edge t+len+3 if unblocked. Throughput: one vector per len+4 clocks.
- Rate bound: each rate ≤ len (Rel<256 at threshold 256). len=0 is never used.
- abort:
  - Synchronous, priority below rst_n and above all else.
  - State→IDLE, out_valid→0, counter→0, sm_cycle_start deasserts next clock.
  - sm_rel and win_count are kept; the next accepted vector flushes normally.
- cfg_window_len changes mid-window do not affect the current window.
- in_rel changes while not in IDLE are ignored.

Decomposition:
- Shared package softmax_pkg:
  - REL_W, N_PAIR, PAIR_* index constants (AB=0..CD=5), pack/unpack slice helpers.
  - State enum (IDLE, FLUSH, RUN, END, CAPTURE).
  - DEF_WINDOW.
- Sub-module result_buf_1e: single-entry valid/ready output register holding rate+winner. It is natural and reusable by other handshake stages.

Test Plan:
- Single vector: in_rel all channels 128, cfg_window_len=16, out_ready=1.
  - sm_cycle_start high exactly 1 clk at accept+1 and accept+18.
  - out_valid at accept+19; out_rate each channel 8; win_count=1.
- Winner/inhibition: ab=200, others 40, len=32.
  - out_winner=0.
  - rate_ab ≥ rate of every other channel; all rates ≤32.
- Backpressure: out_ready=0 for 50 clks after the first result while a second vector is accepted.
  - Controller stalls in CAPTURE with in_ready=0; first result unchanged.
  - Raising out_ready delivers the second result the next clk.
- cfg_window_len=0 → window length 64: second sm_cycle_start at accept+66. Also change cfg mid-RUN → no effect on the current window.
- abort asserted during RUN → next clk IDLE, in_ready=1, no out_valid. A subsequent vector produces rates identical to a clean run (stale accumulators flushed).
- rst_n low mid-CAPTURE with out_valid=1 → after one clk all outputs are at reset values; win_count wraps 0xFFFF→0 on a forced-count run.

Source files
------------

// File: rtl/softmax_window_ctrl_pkg.sv
// Shared types and constants for the rate-softmax window sequencer.
// Pair channels are packed with AB in the least-significant byte.
package softmax_window_ctrl_pkg;

    localparam int REL_W  = 8;
    localparam int N_PAIR = 6;
    localparam int VEC_W  = REL_W * N_PAIR;
    localparam int WIN_W  = 3;

    localparam int PAIR_AB = 0;
    localparam int PAIR_AC = 1;
    localparam int PAIR_AD = 2;
    localparam int PAIR_BC = 3;
    localparam int PAIR_BD = 4;
    localparam int PAIR_CD = 5;

    localparam logic [7:0] DEF_WINDOW = 8'd64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        RUN     = 3'd2,
        END     = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    function automatic logic [REL_W-1:0] get_ch(input logic [VEC_W-1:0] vec, input int idx);
        return vec[idx*REL_W +: REL_W];
    endfunction

    function automatic logic [VEC_W-1:0] set_ch(input logic [VEC_W-1:0] vec, input int idx,
                                                input logic [REL_W-1:0] val);
        logic [VEC_W-1:0] res;
        res = vec;
        res[idx*REL_W +: REL_W] = val;
        return res;
    endfunction

endpackage

// File: rtl/softmax_window_ctrl_if.sv
// Input vector and result handshakes of the window sequencer.
// The controller takes the slave side; its producer/consumer take the master side.
interface softmax_window_ctrl_if;
    import softmax_window_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_rel;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_rate;
    logic [WIN_W-1:0] out_winner;

    modport master (
        output in_valid, in_rel, out_ready,
        input  in_ready, out_valid, out_rate, out_winner
    );

    modport slave (
        input  in_valid, in_rel, out_ready,
        output in_ready, out_valid, out_rate, out_winner
    );

endinterface

// File: rtl/softmax_window_ctrl_result_buf_1e.sv
// result_buf_1e: single-entry valid/ready register holding rates and winner.
// A load and a drain in the same clock replace the entry and keep it valid.
module softmax_window_ctrl_result_buf_1e
    import softmax_window_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [VEC_W-1:0] in_rate,
    input  logic [WIN_W-1:0] in_winner,
    output logic             can_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_rate,
    output logic [WIN_W-1:0] out_winner
);

    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_rate   <= '0;
            out_winner <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (load && can_load) begin
            out_valid  <= 1'b1;
            out_rate   <= in_rate;
            out_winner <= in_winner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/softmax_window_ctrl.sv
// Window sequencer for the lateral-inhibition rate softmax: holds one Rel vector,
// brackets a RUN window with flush/end pulses and buffers the resulting rates.
module softmax_window_ctrl
    import softmax_window_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic [7:0]            cfg_window_len,
    softmax_window_ctrl_if.slave  bus,
    output logic                  sm_cycle_start,
    output logic [VEC_W-1:0]      sm_rel,
    input  logic [VEC_W-1:0]      sm_rate,
    input  logic [WIN_W-1:0]      sm_winner,
    output logic [15:0]           win_count
);

    state_t     state;
    logic [7:0] len;
    logic [7:0] cnt;
    logic       buf_can_load;

    assign bus.in_ready   = (state == IDLE);
    assign sm_cycle_start = (state == FLUSH) || (state == END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sm_rel    <= '0;
            len       <= DEF_WINDOW;
            cnt       <= '0;
            win_count <= '0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sm_rel <= bus.in_rel;
                        len    <= (cfg_window_len == 8'd0) ? DEF_WINDOW : cfg_window_len;
                        state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // len is latched at accept, so cfg edits only affect the next window
                    if (cnt == len - 8'd1) begin
                        state <= END;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                END: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (buf_can_load) begin
                        win_count <= win_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    softmax_window_ctrl_result_buf_1e u_result_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (abort),
        .load       (state == CAPTURE),
        .in_rate    (sm_rate),
        .in_winner  (sm_winner),
        .can_load   (buf_can_load),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_rate   (bus.out_rate),
        .out_winner (bus.out_winner)
    );

endmodule
